// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port VRAM between video fetch (ph0 slots),
// a host single-word port and a fill/copy block engine.
// Priority in a grant cycle: host first, then the engine.
module vram_arbiter (
  input  logic        clk,
  input  logic        nreset,
  input  logic        ph0,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [12:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  input  logic        blk_start,
  input  logic        blk_op,
  input  logic [12:0] blk_src,
  input  logic [12:0] blk_dst,
  input  logic [12:0] blk_len,
  input  logic [15:0] blk_fill,
  output logic        blk_busy,
  output logic        blk_done,
  output logic        ram_en,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_CRD  = 3'd2,
    S_CLAT = 3'd3,
    S_CWR  = 3'd4,
    S_DONE = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic        op_q,     op_d;
  logic [12:0] src_q,    src_d;
  logic [12:0] dst_q,    dst_d;
  logic [12:0] len_q,    len_d;
  logic [15:0] fill_q,   fill_d;
  logic [15:0] buf_q,    buf_d;
  logic        busy_q,   busy_d;
  logic        ack_q,    ack_d;

  logic        host_go;
  logic        eng_gnt;

  // The host is issued in any free slot except the cycle of its own ack
  // (req is still high then); gating with nreset keeps ram_en low in reset.
  assign host_go = nreset & ~ph0 & host_req & ~ack_q;
  assign eng_gnt = ~ph0 & ~host_go;

  assign host_ack   = ack_q;
  assign host_rdata = ack_q ? ram_rdata : 16'h0000;
  assign blk_busy   = busy_q;
  assign blk_done   = (state_q == S_DONE);

  // State and datapath registers; reset abandons any block command.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      src_q   <= 13'h0000;
      dst_q   <= 13'h0000;
      len_q   <= 13'h0000;
      fill_q  <= 16'h0000;
      buf_q   <= 16'h0000;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Engine next-state logic; states waiting for a grant hold everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fill_d  = fill_q;
    buf_d   = buf_q;
    busy_d  = busy_q;
    ack_d   = host_go;
    case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          // Command latched last cycle: dispatch on length and opcode.
          if (len_q == 13'd0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
          end else if (op_q) begin
            state_d = S_CRD;
          end else begin
            state_d = S_FILL;
          end
        end else if (blk_start) begin
          op_d   = blk_op;
          src_d  = blk_src;
          dst_d  = blk_dst;
          len_d  = blk_len;
          fill_d = blk_fill;
          busy_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (eng_gnt) begin
          dst_d = dst_q + 13'd1;
          len_d = len_q - 13'd1;
          if (len_q == 13'd1) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_CRD: begin
        if (eng_gnt) begin
          state_d = S_CLAT;
        end else begin
          state_d = S_CRD;
        end
      end
      S_CLAT: begin
        buf_d   = ram_rdata;
        state_d = S_CWR;
      end
      S_CWR: begin
        if (eng_gnt) begin
          src_d = src_q + 13'd1;
          dst_d = dst_q + 13'd1;
          len_d = len_q - 13'd1;
          if (len_q == 13'd1) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
          end else begin
            state_d = S_CRD;
          end
        end else begin
          state_d = S_CWR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // RAM port mux: host beats engine; every field is zero when not enabled.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 13'h0000;
    ram_wdata = 16'h0000;
    if (host_go) begin
      ram_en    = 1'b1;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end else if (eng_gnt) begin
      case (state_q)
        S_FILL: begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = dst_q;
          ram_wdata = fill_q;
        end
        S_CRD: begin
          ram_en    = 1'b1;
          ram_addr  = src_q;
        end
        S_CWR: begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = dst_q;
          ram_wdata = buf_q;
        end
        default: begin
          ram_en    = 1'b0;
        end
      endcase
    end else begin
      ram_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: expected RAM transactions are queued
// when stimulus is driven and popped as the DUT presents them on the port.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic        ph0;
  logic        host_req, host_we;
  logic [12:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        blk_start, blk_op;
  logic [12:0] blk_src, blk_dst, blk_len;
  logic [15:0] blk_fill;
  logic        blk_busy, blk_done;
  logic        ram_en, ram_we;
  logic [12:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_on = 1'b0;

  logic [29:0] sb[$];
  logic [15:0] mem  [0:8191];
  logic [15:0] gold [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_addr = 13'h0000;
  logic [15:0] pl_data = 16'h0000;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .nreset(nreset), .ph0(ph0),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .blk_start(blk_start), .blk_op(blk_op), .blk_src(blk_src),
    .blk_dst(blk_dst), .blk_len(blk_len), .blk_fill(blk_fill),
    .blk_busy(blk_busy), .blk_done(blk_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural VRAM: one-cycle read latency, plus a bench preload port.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Port monitor: video slots stay free, idle port is all zero, and each
  // access matches the next expected transaction.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ph0) check("ph0_block", {31'd0, ram_en}, 32'd0);
      if (ram_en) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", {31'd0, ram_en}, 32'd0);
        end else begin
          check("ram_txn", {2'd0, ram_we, ram_addr, ram_wdata}, {2'd0, sb.pop_front()});
        end
      end else begin
        check("idle_zero", {2'd0, ram_we, ram_addr, ram_wdata}, 32'd0);
      end
    end
  end

  task automatic preload(input logic [12:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    gold[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Host single-word access; stall = number of leading ph0 cycles.
  task automatic host_op(input logic we, input logic [12:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input int stall);
    int lat;
    bit got;
    sb.push_back({we, a, (we ? wd : 16'h0000)});
    if (we) gold[a] = wd;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    ph0 = (stall > 0);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (host_ack) got = 1'b1;
      else begin
        @(posedge clk); #1;
        if (lat >= stall) ph0 = 1'b0;
      end
    end
    check("host_ack_lat", lat, stall + 2);
    if (!we) check("host_rdata", {16'd0, host_rdata}, {16'd0, exp_rd});
    @(posedge clk); #1;
    host_req = 1'b0; host_we = 1'b0; host_addr = 13'h0000; host_wdata = 16'h0000;
    ph0 = 1'b0;
    @(negedge clk);
    check("host_ack_pulse", {31'd0, host_ack}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Block command with optional ignored restart and concurrent host write.
  task automatic run_blk(input logic op, input logic [12:0] src, input logic [12:0] dst,
                         input logic [12:0] len, input logic [15:0] fill,
                         input int retry_cyc, input int host_cyc,
                         input logic [12:0] ha, input logic [15:0] hd, input int busy_exp);
    int busy_cnt, done_cnt, ack_cnt, after_done;
    bit ack_now;
    logic [12:0] s, d;
    if (host_cyc > 0) begin
      sb.push_back({1'b1, ha, hd});
      gold[ha] = hd;
    end
    s = src; d = dst;
    for (int i = 0; i < int'(len); i++) begin
      if (op) begin
        sb.push_back({1'b0, s, 16'h0000});
        sb.push_back({1'b1, d, gold[s]});
        gold[d] = gold[s];
        s = s + 13'd1;
      end else begin
        sb.push_back({1'b1, d, fill});
        gold[d] = fill;
      end
      d = d + 13'd1;
    end
    blk_op = op; blk_src = src; blk_dst = dst; blk_len = len; blk_fill = fill;
    blk_start = 1'b1;
    busy_cnt = 0; done_cnt = 0; ack_cnt = 0; after_done = 0;
    for (int i = 0; i < 60 && after_done < 2; i++) begin
      @(negedge clk);
      if (blk_busy) busy_cnt++;
      if (blk_done) done_cnt++;
      ack_now = host_ack;
      if (host_ack) ack_cnt++;
      if (done_cnt > 0) after_done++;
      @(posedge clk); #1;
      blk_start = (i + 1 == retry_cyc);
      if (i + 1 == retry_cyc) begin
        blk_dst = 13'h0AAA; blk_len = 13'd5;
      end
      if (i + 1 == host_cyc) begin
        host_req = 1'b1; host_we = 1'b1; host_addr = ha; host_wdata = hd;
      end else if (ack_now) begin
        host_req = 1'b0; host_we = 1'b0; host_addr = 13'h0000; host_wdata = 16'h0000;
      end
    end
    blk_start = 1'b0;
    check("blk_done_cnt", done_cnt, 1);
    check("blk_busy_cyc", busy_cnt, busy_exp);
    if (host_cyc > 0) check("blk_host_ack", ack_cnt, 1);
    check("sb_drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; ph0 = 1'b0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 13'h0000; host_wdata = 16'h0000;
    blk_start = 1'b0; blk_op = 1'b0; blk_src = 13'h0000; blk_dst = 13'h0000;
    blk_len = 13'h0000; blk_fill = 16'h0000;
    #2;
    check("rst_ram_en",   {31'd0, ram_en},   32'd0);
    check("rst_host_ack", {31'd0, host_ack}, 32'd0);
    check("rst_blk_busy", {31'd0, blk_busy}, 32'd0);
    check("rst_blk_done", {31'd0, blk_done}, 32'd0);
    check("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    mon_on = 1'b1;

    // Host write, then a read that arrives in a video slot.
    host_op(1'b1, 13'h0123, 16'hBEEF, 16'h0000, 0);
    preload(13'h0456, 16'h55AA);
    host_op(1'b0, 13'h0456, 16'h0000, 16'h55AA, 1);
    host_op(1'b0, 13'h0123, 16'h0000, 16'hBEEF, 0);

    // Fill across the top of the address space with an ignored restart.
    run_blk(1'b0, 13'h0000, 13'h1FFE, 13'd3, 16'hA5A5, 2, 0, 13'h0000, 16'h0000, 4);
    check("fill_1ffe", {16'd0, mem[13'h1FFE]}, {16'd0, 16'hA5A5});
    check("fill_0000", {16'd0, mem[13'h0000]}, {16'd0, 16'hA5A5});
    check("fill_0aaa_untouched", {31'd0, (mem[13'h0AAA] === 16'hA5A5)}, 32'd0);

    // Copy with a host write landing on the engine's first read slot.
    preload(13'h0010, 16'h1111);
    preload(13'h0011, 16'h2222);
    run_blk(1'b1, 13'h0010, 13'h0100, 13'd2, 16'h0000, 0, 2, 13'h0200, 16'hCAFE, 8);
    check("copy_dst0", {16'd0, mem[13'h0100]}, {16'd0, 16'h1111});
    check("copy_dst1", {16'd0, mem[13'h0101]}, {16'd0, 16'h2222});
    check("copy_host", {16'd0, mem[13'h0200]}, {16'd0, 16'hCAFE});

    // Zero-length command.
    run_blk(1'b0, 13'h0000, 13'h0700, 13'd0, 16'h7777, 0, 0, 13'h0000, 16'h0000, 1);

    // Reset in the middle of a fill with a host ack in flight.
    mon_on = 1'b0;
    blk_op = 1'b0; blk_dst = 13'h0300; blk_len = 13'd10; blk_fill = 16'h1234;
    blk_start = 1'b1;
    @(posedge clk); #1 blk_start = 1'b0;
    repeat (3) @(posedge clk);
    #1 host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0400; host_wdata = 16'h0001;
    @(posedge clk); #1;
    check("pre_rst_busy", {31'd0, blk_busy}, 32'd1);
    check("pre_rst_ack",  {31'd0, host_ack}, 32'd1);
    #1 nreset = 1'b0;
    #1;
    check("mid_rst_ram_en",   {31'd0, ram_en},   32'd0);
    check("mid_rst_blk_busy", {31'd0, blk_busy}, 32'd0);
    check("mid_rst_blk_done", {31'd0, blk_done}, 32'd0);
    check("mid_rst_host_ack", {31'd0, host_ack}, 32'd0);
    host_req = 1'b0; host_we = 1'b0; host_addr = 13'h0000; host_wdata = 16'h0000;
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1 nreset = 1'b1;
    mon_on = 1'b1;
    // First slot after release goes straight to the host; the fill must not resume.
    host_op(1'b0, 13'h1FFF, 16'h0000, 16'hA5A5, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_busy", {31'd0, blk_busy}, 32'd0);
      check("post_rst_done", {31'd0, blk_done}, 32'd0);
    end
    check("post_rst_sb", sb.size(), 0);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
